z_result_stage: RTL and testbench

Z_RESULT_STAGE -- requirements
Module: z_result_stage

---
 rtl/z_result_stage.sv | 151 +++++++++++++++
 tb/tb_z_result_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/z_result_stage.sv
// Purpose : 2-entry in-order result buffer between the rotate/shift/ALU producers and the Z result consumer.
// Latency : a push into an empty buffer is visible on ZLO/ZHI one cycle later.
// Backpres: in_ready depends only on registered state (low when both entries are held); out_ready never reaches in_ready.
//
// Ports   : clock, clear (async active-low reset), in_valid/in_ready/in_lo/in_hi/in_wide (producer side),
//           flush (sync discard), out_valid/out_ready/ZLO/ZHI/z_flag/n_flag (consumer side), occupancy (0..2).
// Option  : define Z_FLAGS_EN to compute zero/negative flags at push time and store them per entry;
//           without it z_flag/n_flag are tied to 0 and no flag storage exists.
module z_result_stage (
    input  logic        clock,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_lo,
    input  logic [31:0] in_hi,
    input  logic        in_wide,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] ZLO,
    output logic [31:0] ZHI,
    output logic        z_flag,
    output logic        n_flag,
    output logic [1:0]  occupancy
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state_q;

    // Entry 0 is always the head; entry 1 is only meaningful in FULL.
    logic [31:0] lo0_q, hi0_q, lo1_q, hi1_q;

    logic        push;
    logic        pop;
    logic [31:0] new_hi;
    logic        load0_new;   // incoming result becomes the head
    logic        load1_new;   // incoming result queues behind the head
    logic        shift_up;    // second entry moves to head

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;

    assign push   = in_valid & in_ready;
    assign pop    = out_valid & out_ready;
    assign new_hi = in_wide ? in_hi : 32'h0;

    always_comb begin
        load0_new = 1'b0;
        load1_new = 1'b0;
        shift_up  = 1'b0;
        if (!flush) begin
            case (state_q)
                EMPTY:   load0_new = push;
                // Simultaneous push and pop: the old head leaves, so the new result takes its place.
                ONE: begin
                    load0_new = push & pop;
                    load1_new = push & ~pop;
                end
                FULL:    shift_up  = pop;
                default: ;
            endcase
        end
    end

    // Occupancy FSM; flush wins over any push/pop in the same cycle.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= EMPTY;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (push) state_q <= ONE;
                ONE: begin
                    if (push && !pop)      state_q <= FULL;
                    else if (pop && !push) state_q <= EMPTY;
                end
                FULL:    if (pop) state_q <= ONE;
                default: state_q <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            lo0_q <= 32'h0;
            hi0_q <= 32'h0;
            lo1_q <= 32'h0;
            hi1_q <= 32'h0;
        end else begin
            if (load0_new) begin
                lo0_q <= in_lo;
                hi0_q <= new_hi;
            end else if (shift_up) begin
                lo0_q <= lo1_q;
                hi0_q <= hi1_q;
            end
            if (load1_new) begin
                lo1_q <= in_lo;
                hi1_q <= new_hi;
            end
        end
    end

    // Entry storage is left stale when popped; the outputs are masked instead.
    assign ZLO = out_valid ? lo0_q : 32'h0;
    assign ZHI = out_valid ? hi0_q : 32'h0;

`ifdef Z_FLAGS_EN
    logic z0_q, n0_q, z1_q, n1_q;
    logic new_z, new_n;

    assign new_z = (new_hi == 32'h0) && (in_lo == 32'h0);
    assign new_n = in_wide ? in_hi[31] : in_lo[31];

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            z0_q <= 1'b0;
            n0_q <= 1'b0;
            z1_q <= 1'b0;
            n1_q <= 1'b0;
        end else begin
            if (load0_new) begin
                z0_q <= new_z;
                n0_q <= new_n;
            end else if (shift_up) begin
                z0_q <= z1_q;
                n0_q <= n1_q;
            end
            if (load1_new) begin
                z1_q <= new_z;
                n1_q <= new_n;
            end
        end
    end

    assign z_flag = out_valid & z0_q;
    assign n_flag = out_valid & n0_q;
`else
    assign z_flag = 1'b0;
    assign n_flag = 1'b0;
`endif

endmodule

// File: tb/tb_z_result_stage.sv
// Bench for z_result_stage: directed vector table, random traffic against a queue model, async reset mid-operation.
module tb_z_result_stage;

`ifdef Z_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_lo;
    logic [31:0] in_hi;
    logic        in_wide;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ZLO;
    logic [31:0] ZHI;
    logic        z_flag;
    logic        n_flag;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    z_result_stage dut (
        .clock     (clock),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_lo     (in_lo),
        .in_hi     (in_hi),
        .in_wide   (in_wide),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ZLO       (ZLO),
        .ZHI       (ZHI),
        .z_flag    (z_flag),
        .n_flag    (n_flag),
        .occupancy (occupancy)
    );

    typedef struct {
        logic        iv;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        wd;
        logic        fl;
        logic        ordy;
        logic [1:0]  occ;
        logic        vld;
        logic [31:0] zlo;
        logic [31:0] zhi;
        logic        rdy;
        logic        z;
        logic        n;
    } vec_t;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        z;
        logic        n;
    } ent_t;

    vec_t vecs[14];
    ent_t mq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] occ, input logic vld,
                            input logic [31:0] zlo, input logic [31:0] zhi,
                            input logic rdy, input logic z, input logic n);
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(vld));
        chk({tag, ".ZLO"}, ZLO, zlo);
        chk({tag, ".ZHI"}, ZHI, zhi);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, ".z_flag"}, 32'(z_flag), 32'(FLAGS & z));
        chk({tag, ".n_flag"}, 32'(n_flag), 32'(FLAGS & n));
    endtask

    task automatic drive(input logic iv, input logic [31:0] lo, input logic [31:0] hi,
                         input logic wd, input logic fl, input logic ordy);
        in_valid  = iv;
        in_lo     = lo;
        in_hi     = hi;
        in_wide   = wd;
        flush     = fl;
        out_ready = ordy;
    endtask

    // Reference: a plain FIFO of at most two results, flags computed from the rules directly.
    task automatic model_step(input logic iv, input logic [31:0] lo, input logic [31:0] hi,
                              input logic wd, input logic fl, input logic ordy);
        ent_t e;
        bit   can_push;
        bit   do_pop;
        can_push = (mq.size() < 2);
        do_pop   = (mq.size() > 0) && ordy;
        e.lo = lo;
        e.hi = wd ? hi : 32'h0;
        e.z  = (e.lo == 0) && (e.hi == 0);
        e.n  = wd ? hi[31] : lo[31];
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (iv && can_push) mq.push_back(e);
        end
    endtask

    initial begin
        //          iv    lo            hi            wd    fl    ordy  occ   vld   zlo           zhi           rdy   z     n
        vecs[0]  = '{1'b1, 32'h80000001, 32'h0,        1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 32'h80000001, 32'h0,        1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'h1,        32'h0,        1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 32'h1,        32'h0,        1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 32'h2,        32'h0,        1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 32'h1,        32'h0,        1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 32'h3,        32'h0,        1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 32'h1,        32'h0,        1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 32'h3,        32'h0,        1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h2,        32'h0,        1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'h3,        32'h0,        1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'hA,        32'h0,        1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 32'hA,        32'h0,        1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 32'hB,        32'h0,        1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'hB,        32'h0,        1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'h11,       32'h0,        1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 32'hB,        32'h0,        1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 32'h99,       32'h0,        1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 32'h0,        32'hFFFF0000, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 32'h0,        32'hFFFF0000, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 32'h0,        32'hDEAD,     1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 32'h0,        32'h0,        1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0};

        clear = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #12;
        chk_outs("reset", 2'd0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        #5 clear = 1'b1;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].iv, vecs[i].lo, vecs[i].hi, vecs[i].wd, vecs[i].fl, vecs[i].ordy);
            @(posedge clock);
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].occ, vecs[i].vld, vecs[i].zlo, vecs[i].zhi,
                     vecs[i].rdy, vecs[i].z, vecs[i].n);
        end

        // Random traffic against the queue model
        mq.delete();
        for (int c = 0; c < 400; c++) begin
            logic        r_iv, r_wd, r_fl, r_or;
            logic [31:0] r_lo, r_hi;
            r_iv = 1'($urandom_range(0, 1));
            r_wd = 1'($urandom_range(0, 1));
            r_fl = ($urandom_range(0, 15) == 0);
            r_or = ($urandom_range(0, 2) != 0);
            r_lo = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
            r_hi = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
            drive(r_iv, r_lo, r_hi, r_wd, r_fl, r_or);
            model_step(r_iv, r_lo, r_hi, r_wd, r_fl, r_or);
            @(posedge clock);
            #1;
            if (mq.size() == 0)
                chk_outs($sformatf("rnd%0d", c), 2'd0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
            else
                chk_outs($sformatf("rnd%0d", c), 2'(mq.size()), 1'b1, mq[0].lo, mq[0].hi,
                         (mq.size() < 2), mq[0].z, mq[0].n);
        end

        // Async reset while FULL, then recovery
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clock); #1;
        drive(1'b1, 32'h21, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #1;
        drive(1'b1, 32'h22, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #1;
        chk_outs("prefill", 2'd2, 1'b1, 32'h21, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2 clear = 1'b0;
        #1;
        chk_outs("async_clr", 2'd0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        clear = 1'b1;
        drive(1'b1, 32'h5, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #1;
        chk_outs("post_clr", 2'd1, 1'b1, 32'h5, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
